pipeline_run_ctrl: RTL
======================

# pipeline_run_ctrl

Execution controller that drives the pipeline-wide enable consumed by the PC register and the inter-stage registers, turning host commands from the debug unit into continuous-run, N-step, stop and clear sequences. It counts executed cycles, stops on a HALT instruction reported from WB or on a watchdog limit, and issues a one-cycle flush pulse that returns the PC and the pipeline to their reset state. It sits between the debug/UART command decoder and the datapath.

## Interface
- CNT_W, 32, width of the executed-cycle counter
- STEP_W, 8, width of the step-count field
- MAX_CYCLES, 0, watchdog limit on executed cycles; 0 disables the watchdog
- i_clk  in  1  rising-edge clock
- i_reset  in  1  asynchronous, active-low reset
- i_cmd_valid  in  1  command strobe; i_cmd and i_step_n are sampled when high
- i_cmd  in  2  00 CLEAR, 01 RUN, 10 STEP, 11 STOP
- i_step_n  in  STEP_W  number of cycles for STEP; 0 is treated as 1
- i_halt_detected  in  1  HALT instruction in WB this cycle; valid only while o_enable=1
- o_enable  out  1  pipeline/PC enable; 1 only in RUN or STEP
- o_flush  out  1  one-cycle pulse that resets the PC and pipeline registers
- o_state  out  2  00 IDLE, 01 RUN, 10 STEP, 11 HALTED
- o_cycle_count  out  CNT_W  cycles executed with o_enable=1 since the last CLEAR; saturates at all-ones
- o_done  out  1  one-cycle pulse when a run or step sequence ends, by step completion or halt
- o_timeout  out  1  sticky; set on watchdog expiry and cleared by CLEAR

## Operation
- Reset (i_reset=0, asynchronous) forces: state IDLE, o_enable=0, o_flush=0, o_cycle_count=0, o_done=0, o_timeout=0, step counter=0.
- o_enable is decoded from the state: it is 1 exactly when the state is RUN or STEP.
- IDLE:
  - RUN goes to RUN.
  - STEP loads the step counter with max(i_step_n,1) and goes to STEP.
  - CLEAR zeroes o_cycle_count, clears o_timeout, pulses o_flush and stays in IDLE.
  - STOP is ignored.
- RUN and STEP: every cycle with o_enable=1 increments o_cycle_count (saturating). Exit priority is, highest first:
  1. i_halt_detected: go to HALTED and pulse o_done.
  2. Watchdog: MAX_CYCLES≠0 and the incremented count equals MAX_CYCLES. Go to HALTED, set o_timeout, no o_done.
  3. STOP command: go to IDLE, no o_done.
  4. STEP state only, step counter equals 1: go to IDLE and pulse o_done. Otherwise the step counter decrements.
  - RUN, STEP and CLEAR commands are ignored while in RUN or STEP.
- HALTED: only CLEAR is accepted. It goes to IDLE, zeroes the count, clears o_timeout and pulses o_flush. All other commands are ignored.
- The cycle in which halt, watchdog expiry, STOP or step completion is detected is itself an enabled cycle and is counted.

## Timing
- Commands are sampled at the rising edge where i_cmd_valid=1. The new state, and therefore o_enable, appears in the following cycle, so the pipeline sees its first enabled edge one cycle after acceptance.
- STEP N produces exactly N consecutive cycles with o_enable=1. o_done is high during the cycle after the last enabled cycle, and o_enable is 0 at that point.
- o_flush and o_done are registered and high for exactly one cycle.
- Halt response: i_halt_detected=1 at edge k gives o_enable=0 from cycle k+1. No further PC update occurs.
- Asynchronous reset during RUN drops o_enable immediately, without waiting for a clock edge.
- Saturated counter: the count stays at all-ones and the watchdog comparison still applies.

## Test plan
- Reset, then STEP with i_step_n=3. o_enable is high for exactly 3 cycles, then o_state=00, o_cycle_count=3 and o_done pulses once.
- STEP with i_step_n=0 gives exactly 1 enabled cycle and o_cycle_count=1.
- RUN, with i_halt_detected asserted on the 10th enabled cycle. o_state=11, o_cycle_count=10, o_done pulses and o_enable=0. A following RUN is ignored. CLEAR then gives o_flush for 1 cycle, count 0 and state IDLE.
- MAX_CYCLES=5, RUN. After 5 enabled cycles, o_state=11, o_timeout=1 and no o_done. CLEAR returns o_timeout to 0.
- RUN, then STOP after 4 enabled cycles. State is IDLE, o_cycle_count=4 and o_done never pulses. A second RUN resumes counting from 4.
- Drive i_reset=0 asynchronously mid-RUN. o_enable falls before the next clock edge and all outputs go to their reset values. Simultaneous halt and STOP resolves to HALTED.

Source files
------------

// File: rtl/pipeline_run_ctrl.sv
// pipeline_run_ctrl: run/step/stop/clear execution controller producing the
// pipeline-wide enable, a one-cycle flush pulse, a cycle counter and status.
//
// Ports:
//   i_clk            rising-edge clock
//   i_reset          asynchronous active-low reset
//   i_cmd_valid      command strobe; i_cmd / i_step_n sampled when high
//   i_cmd            00 CLEAR, 01 RUN, 10 STEP, 11 STOP
//   i_step_n         step count for STEP (0 behaves as 1)
//   i_halt_detected  HALT retiring in WB (meaningful only while enabled)
//   o_enable         PC / inter-stage register enable (RUN or STEP)
//   o_flush          one-cycle pulse returning PC and pipeline to reset state
//   o_state          00 IDLE, 01 RUN, 10 STEP, 11 HALTED
//   o_cycle_count    enabled cycles since last CLEAR, saturating
//   o_done           one-cycle pulse when a run/step ends by completion or halt
//   o_timeout        sticky watchdog expiry flag, cleared by CLEAR
module pipeline_run_ctrl #(
    parameter int CNT_W      = 32,
    parameter int STEP_W     = 8,
    parameter int MAX_CYCLES = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    input  logic [1:0]        i_cmd,
    input  logic [STEP_W-1:0] i_step_n,
    input  logic              i_halt_detected,
    output logic              o_enable,
    output logic              o_flush,
    output logic [1:0]        o_state,
    output logic [CNT_W-1:0]  o_cycle_count,
    output logic              o_done,
    output logic              o_timeout
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_STEP   = 2'b10,
        S_HALTED = 2'b11
    } state_t;

    localparam logic [1:0] CMD_CLEAR = 2'b00;
    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_STOP  = 2'b11;

    localparam logic [CNT_W-1:0]  LP_MAX  = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0]  LP_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [STEP_W-1:0] LP_SONE = {{(STEP_W-1){1'b0}}, 1'b1};
    localparam bit                LP_WD_EN = (MAX_CYCLES != 0);

    state_t              r_state;
    state_t              w_next_state;
    logic [STEP_W-1:0]   r_step_cnt;
    logic [STEP_W-1:0]   w_next_step;
    logic [CNT_W-1:0]    r_cycle_count;
    logic [CNT_W-1:0]    w_next_count;
    logic                r_flush;
    logic                w_next_flush;
    logic                r_done;
    logic                w_next_done;
    logic                r_timeout;
    logic                w_next_timeout;

    logic [CNT_W-1:0]    w_cnt_inc;
    logic [STEP_W-1:0]   w_step_load;
    logic                w_wd_hit;
    logic                w_stop_cmd;
    logic                w_clear_cmd;

    // Count holds at all-ones once saturated; watchdog still compares it.
    assign w_cnt_inc   = (&r_cycle_count) ? r_cycle_count
                                          : r_cycle_count + LP_ONE;
    assign w_step_load = (i_step_n == '0) ? LP_SONE : i_step_n;
    assign w_wd_hit    = LP_WD_EN && (w_cnt_inc == LP_MAX);
    assign w_stop_cmd  = i_cmd_valid && (i_cmd == CMD_STOP);
    assign w_clear_cmd = i_cmd_valid && (i_cmd == CMD_CLEAR);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_step_cnt    <= '0;
            r_cycle_count <= '0;
            r_flush       <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_step_cnt    <= w_next_step;
            r_cycle_count <= w_next_count;
            r_flush       <= w_next_flush;
            r_done        <= w_next_done;
            r_timeout     <= w_next_timeout;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_next_step    = r_step_cnt;
        w_next_count   = r_cycle_count;
        w_next_flush   = 1'b0;
        w_next_done    = 1'b0;
        w_next_timeout = r_timeout;

        unique case (r_state)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    unique case (i_cmd)
                        CMD_CLEAR: begin
                            w_next_count   = '0;
                            w_next_timeout = 1'b0;
                            w_next_flush   = 1'b1;
                        end
                        CMD_RUN: begin
                            w_next_state = S_RUN;
                        end
                        CMD_STEP: begin
                            w_next_step  = w_step_load;
                            w_next_state = S_STEP;
                        end
                        default: begin
                        end
                    endcase
                end
            end

            S_RUN, S_STEP: begin
                // Every cycle here is enabled, including the exit cycle.
                w_next_count = w_cnt_inc;
                if (i_halt_detected) begin
                    w_next_state = S_HALTED;
                    w_next_done  = 1'b1;
                end else if (w_wd_hit) begin
                    w_next_state   = S_HALTED;
                    w_next_timeout = 1'b1;
                end else if (w_stop_cmd) begin
                    w_next_state = S_IDLE;
                end else if (r_state == S_STEP) begin
                    if (r_step_cnt == LP_SONE) begin
                        w_next_state = S_IDLE;
                        w_next_done  = 1'b1;
                    end else begin
                        w_next_step = r_step_cnt - LP_SONE;
                    end
                end
            end

            S_HALTED: begin
                if (w_clear_cmd) begin
                    w_next_state   = S_IDLE;
                    w_next_count   = '0;
                    w_next_timeout = 1'b0;
                    w_next_flush   = 1'b1;
                end
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Decoded straight from state so an async reset drops it immediately.
    assign o_enable      = (r_state == S_RUN) || (r_state == S_STEP);
    assign o_flush       = r_flush;
    assign o_state       = r_state;
    assign o_cycle_count = r_cycle_count;
    assign o_done        = r_done;
    assign o_timeout     = r_timeout;

endmodule
